// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction fetch unit:
//     - XLEN             : datapath / address width
//     - RESET_PC_DEFAULT : default first fetch address after reset
//     - fetch_state_e    : fetch FSM state encoding
//     - word_align()     : clears the byte-offset bits of an address
//     - pc_incr()        : sequential next-PC, wraps modulo 2^XLEN
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Byte distance between consecutive instruction words.
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // leaving reset, no request yet
    ST_REQ  = 2'd1,  // request outstanding, data wanted
    ST_DROP = 2'd2,  // request outstanding, data to be discarded
    ST_HOLD = 2'd3   // instruction held for decode
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // Plain unsigned add: the carry out is dropped, so 0xFFFF_FFFC -> 0x0.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the fetch unit's three handshakes:
//     redirect : pc_load, new_pc_data                (execute -> fetch)
//     imem     : imem_req, imem_addr, imem_ack, imem_rdata
//     decode   : instr_valid, instr, instr_pc, instr_ready
//   modport master : view of the fetch unit itself
//   modport slave  : view of the surrounding pipeline / memory
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  // Redirect from the execute stage
  logic            pc_load;
  logic [XLEN-1:0] new_pc_data;

  // Instruction memory port
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  // Decode handoff
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  modport master (
    input  pc_load, new_pc_data,
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    output pc_load, new_pc_data,
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );

endinterface : fetch_unit_if

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Single-outstanding-request instruction fetch unit. Issues word-aligned
//   requests to instruction memory, hands each fetched word to decode with a
//   valid/ready handshake, and follows branch redirects from execute. A
//   redirect that arrives while a request is in flight lets that request
//   complete on the bus (address held stable) and throws its data away.
//
//   Parameters
//     RESET_PC : first fetch address after reset (word aligned)
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : fetch_unit_if.master (redirect, imem and decode handshakes)
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fetch_state_e    state_q,     state_d;
  logic [XLEN-1:0] pc_q,        pc_d;        // address driven on imem_addr
  logic [XLEN-1:0] redir_q,     redir_d;     // target parked while in DROP
  logic [XLEN-1:0] instr_q,     instr_d;
  logic [XLEN-1:0] instr_pc_q,  instr_pc_d;
  logic            imem_req_q,  imem_req_d;
  logic            valid_q,     valid_d;

  logic [XLEN-1:0] target;

  assign target = word_align(bus.new_pc_data);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_d    = redir_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    unique case (state_q)
      ST_IDLE: begin
        // Redirects are not honoured until the first request is issued.
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (bus.imem_ack) begin
          if (bus.pc_load) begin
            // Data belongs to the wrong path; restart at the target at once.
            pc_d    = target;
            state_d = ST_REQ;
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_incr(pc_q);
            state_d    = ST_HOLD;
          end
        end else if (bus.pc_load) begin
          // The bus transfer cannot be withdrawn: keep pc_q (the bus address)
          // and park the target until the ack retires the stale request.
          redir_d = target;
          state_d = ST_DROP;
        end
      end

      ST_DROP: begin
        if (bus.imem_ack) begin
          // A redirect in the ack cycle is newer than the parked one.
          pc_d    = bus.pc_load ? target : redir_q;
          state_d = ST_REQ;
        end else if (bus.pc_load) begin
          redir_d = target;
        end
      end

      ST_HOLD: begin
        if (bus.pc_load) begin
          // A coincident instr_ready still counts as a completed handshake;
          // either way the held instruction is retired here.
          pc_d    = target;
          state_d = ST_REQ;
        end else if (bus.instr_ready) begin
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they are
    // glitch-free and valid from the first cycle of each state.
    imem_req_d = (state_d == ST_REQ) || (state_d == ST_DROP);
    valid_d    = (state_d == ST_HOLD);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every flop here is reset, including the datapath registers, so
      // instr/instr_pc read as zero and an in-flight request is forgotten.
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      redir_q    <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      imem_req_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_q    <= redir_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      imem_req_q <= imem_req_d;
      valid_q    <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule : fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset; bits [1:0] are zero.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 pc_load  input  1  redirect request from the execute stage's branch logic.
REQ-005 new_pc_data  input  32  redirect target; sampled only when pc_load=1.
REQ-006 imem_req  output  1  instruction-memory request.
REQ-007 imem_addr  output  32  word-aligned fetch address.
REQ-008 imem_ack  input  1  one-cycle pulse: request done, imem_rdata valid this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instr_valid  output  1  instr/instr_pc hold a fetched instruction for decode.
REQ-011 instr_ready  input  1  decode accepts instr this cycle.
REQ-012 instr  output  32  fetched instruction word.
REQ-013 instr_pc  output  32  address instr was fetched from.

Function
REQ-014 FSM states: IDLE, REQ, DROP, HOLD, all registered.
REQ-015 IDLE -> REQ unconditionally on the first edge after reset deasserts.
REQ-016 imem_req SHALL be 1 exactly in REQ and DROP; imem_addr SHALL equal the internal pc register and stay stable while imem_req=1 until imem_ack.
REQ-017 REQ with imem_ack=1 and pc_load=0: capture instr<=imem_rdata, instr_pc<=pc, pc<=pc+4; go to HOLD.
REQ-018 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 instr_valid SHALL be 1 exactly in HOLD; instr and instr_pc stay stable in HOLD.
REQ-020 HOLD with instr_ready=1: go to REQ next cycle, so imem_req is 1 in that cycle at the incremented pc.
REQ-021 Any state except IDLE with pc_load=1: pc<=new_pc_data with bits [1:0] cleared.
REQ-022 REQ with pc_load=1 and imem_ack=0: go to DROP; imem_addr stays at the old address until ack.
REQ-023 DROP with imem_ack=1: discard imem_rdata, go to REQ at the redirected pc.
REQ-024 REQ with pc_load=1 and imem_ack=1 in the same cycle: discard imem_rdata, stay in REQ at the new pc.
REQ-025 HOLD with pc_load=1: drop instr_valid next cycle, go to REQ; if instr_ready=1 in the same cycle, that handshake still counts as accepted.
REQ-026 DROP with a further pc_load=1: latest target wins; stay in DROP until ack.
REQ-027 imem_ack outside REQ/DROP SHALL be ignored.
REQ-028 Minimum issue rate: ack at cycle N -> instr_valid at N+1; handshake at M -> imem_req at M+1.

Reset
REQ-029 While rst=1: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, imem_addr=RESET_PC.
REQ-030 Reset during an outstanding request SHALL abandon it; no imem_rdata is captured and the first post-reset request is at RESET_PC.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, XLEN=32 and the RESET_PC default constant.
REQ-032 Single module; no sub-module.

Verification
REQ-033 Reset release, ack 2 cycles after each req, instr_ready=1 -> fetches at 0x0, 0x4, 0x8; instr_pc matches each address; instr matches rdata.
REQ-034 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0 throughout.
REQ-035 pc_load=1, new_pc_data=0x103 in REQ before ack -> DROP, old address held, ack data discarded, next req at 0x100.
REQ-036 pc_load and imem_ack in the same cycle, target 0x200 -> no instr_valid, next imem_addr=0x200.
REQ-037 pc=0xFFFF_FFFC fetch accepted -> next imem_addr=0x0000_0000.
REQ-038 rst asserted mid-REQ, ack arriving during reset -> instr_valid stays 0, first req after release at RESET_PC.
